// File: rtl/qsys_serial_pkg.sv
// Shared definitions for the Qsys serial link: frame geometry, field slicing
// and the responder state encoding. The master side uses the same slices.
package qsys_serial_pkg;

    localparam int unsigned FRAME_BITS = 65;
    localparam int unsigned RESP_BITS  = 32;
    localparam int unsigned RW_BIT     = 64;
    localparam int unsigned ADDR_MSB   = 63;
    localparam int unsigned ADDR_LSB   = 32;
    localparam int unsigned DATA_MSB   = 31;
    localparam int unsigned DATA_LSB   = 0;

    typedef logic [FRAME_BITS-1:0] frame_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_ACCESS,
        ST_RETURN,
        ST_DRAIN
    } state_t;

    function automatic logic [31:0] frame_addr(input frame_t f);
        return f[ADDR_MSB:ADDR_LSB];
    endfunction

    function automatic logic [31:0] frame_data(input frame_t f);
        return f[DATA_MSB:DATA_LSB];
    endfunction

endpackage

// File: rtl/qsys_serial_shifter.sv
// Parallel-load shift register with a count of shifts since the last load;
// serves as both the command deserialiser and the response serialiser.
module qsys_serial_shifter #(
    parameter int unsigned WIDTH     = 32,
    parameter bit          MSB_FIRST = 1'b1,
    parameter int unsigned CW        = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift,
    input  logic             shift_in,
    output logic [WIDTH-1:0] data,
    output logic             shift_out,
    output logic [CW-1:0]    count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data  <= '0;
            count <= '0;
        end else if (load) begin
            data  <= load_data;
            count <= '0;
        end else if (shift) begin
            if (MSB_FIRST) data <= {data[WIDTH-2:0], shift_in};
            else           data <= {shift_in, data[WIDTH-1:1]};
            count <= count + CW'(1);
        end
    end

    assign shift_out = MSB_FIRST ? data[WIDTH-1] : data[0];

endmodule

// File: rtl/qsys_serial_responder.sv
// Device-end responder: deserialises a 65-bit command from sdi/sle, runs one
// local bus access with stall timeout, and returns a 32-bit result on sdo/srdy.
module qsys_serial_responder #(
    parameter int unsigned address_size = 8,
    parameter int unsigned TIMEOUT      = 255,
    parameter logic [31:0] ERR_DATA     = 32'hDEADBEEF
) (
    input  logic                    csi_MCLK_clk,
    input  logic                    rsi_MRST_reset,
    input  logic                    sdi,
    input  logic                    sle,
    output logic                    sdo,
    output logic                    srdy,
    output logic [address_size-1:0] loc_address,
    output logic                    loc_write,
    output logic                    loc_read,
    output logic [31:0]             loc_writedata,
    input  logic [31:0]             loc_readdata,
    input  logic                    loc_waitrequest,
    output logic                    frame_err
);
    import qsys_serial_pkg::*;

    localparam int unsigned RX_CW = $clog2(FRAME_BITS + 1);
    localparam int unsigned TX_CW = $clog2(RESP_BITS + 1);
    localparam logic [RX_CW-1:0] RX_FULL   = RX_CW'(FRAME_BITS);
    localparam logic [TX_CW-1:0] TX_DONE   = TX_CW'(RESP_BITS);
    localparam logic [TX_CW-1:0] TX_LASTHI = TX_CW'(RESP_BITS - 1);
    localparam logic [7:0]       STALL_MAX = 8'(TIMEOUT - 1);

    state_t state, state_d;
    logic sle_q, sle_qq, start;
    logic [7:0] stall_cnt, stall_cnt_d;

    logic rx_load, rx_shift, rx_sout;
    frame_t rx_data;
    logic [RX_CW-1:0] rx_count;
    logic tx_load, tx_shift, tx_sout;
    logic [RESP_BITS-1:0] tx_load_data, tx_par;
    logic [TX_CW-1:0] tx_count;

    logic rw;
    logic [31:0] wire_addr, wire_data;
    logic unused_bits;

    logic sdo_d, srdy_d, loc_write_d, loc_read_d, frame_err_d;
    logic [address_size-1:0] loc_address_d;
    logic [31:0] loc_writedata_d;

    // Frames start only on a rising sle_q, so a strobe still high on return to IDLE is ignored.
    assign start     = sle_q && !sle_qq;
    assign rw        = rx_data[RW_BIT];
    assign wire_addr = frame_addr(rx_data);
    assign wire_data = frame_data(rx_data);
    assign unused_bits = ^{wire_addr, tx_par, rx_sout};

    qsys_serial_shifter #(.WIDTH(FRAME_BITS), .MSB_FIRST(1'b1)) u_rx (
        .clk(csi_MCLK_clk), .rst(rsi_MRST_reset),
        .load(rx_load), .load_data('0), .shift(rx_shift), .shift_in(sdi),
        .data(rx_data), .shift_out(rx_sout), .count(rx_count)
    );

    qsys_serial_shifter #(.WIDTH(RESP_BITS), .MSB_FIRST(1'b1)) u_tx (
        .clk(csi_MCLK_clk), .rst(rsi_MRST_reset),
        .load(tx_load), .load_data(tx_load_data), .shift(tx_shift), .shift_in(1'b0),
        .data(tx_par), .shift_out(tx_sout), .count(tx_count)
    );

    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            state  <= ST_IDLE;
            sle_q  <= 1'b0;
            sle_qq <= 1'b0;
        end else begin
            state  <= state_d;
            sle_q  <= sle;
            sle_qq <= sle_q;
        end
    end

    always_comb begin
        state_d = state;
        unique case (state)
            ST_IDLE:   if (start) state_d = ST_SHIFT;
            ST_SHIFT: begin
                if (sle_q) begin
                    if (rx_count == RX_FULL) state_d = ST_DRAIN;
                end else begin
                    state_d = (rx_count == RX_FULL) ? ST_ACCESS : ST_DRAIN;
                end
            end
            ST_ACCESS: if (!loc_waitrequest || stall_cnt == STALL_MAX) state_d = ST_RETURN;
            ST_RETURN: if (tx_count == TX_DONE) state_d = ST_IDLE;
            ST_DRAIN:  if (!sle_q) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        loc_address_d   = loc_address;
        loc_writedata_d = loc_writedata;
        loc_write_d     = loc_write;
        loc_read_d      = loc_read;
        sdo_d           = 1'b0;
        srdy_d          = 1'b0;
        frame_err_d     = 1'b0;
        stall_cnt_d     = '0;
        rx_load         = 1'b0;
        rx_shift        = 1'b0;
        tx_load         = 1'b0;
        tx_shift        = 1'b0;
        tx_load_data    = ERR_DATA;
        unique case (state)
            ST_IDLE: begin
                rx_load  = !start;
                rx_shift = start;
            end
            ST_SHIFT: begin
                if (sle_q) begin
                    if (rx_count != RX_FULL) rx_shift = 1'b1;
                    else                     frame_err_d = 1'b1;
                end else if (rx_count == RX_FULL) begin
                    loc_address_d   = wire_addr[address_size-1:0];
                    loc_write_d     = rw;
                    loc_read_d      = !rw;
                    loc_writedata_d = rw ? wire_data : '0;
                end else begin
                    frame_err_d = 1'b1;
                end
            end
            ST_ACCESS: begin
                if (!loc_waitrequest || stall_cnt == STALL_MAX) begin
                    loc_write_d = 1'b0;
                    loc_read_d  = 1'b0;
                    tx_load     = 1'b1;
                    srdy_d      = 1'b1;
                    if (!loc_waitrequest) tx_load_data = rw ? wire_data : loc_readdata;
                end else begin
                    stall_cnt_d = stall_cnt + 8'd1;
                end
            end
            ST_RETURN: begin
                // The leading srdy cycle carries sdo=0, so data trails the strobe by one cycle.
                if (tx_count != TX_DONE) begin
                    tx_shift = 1'b1;
                    sdo_d    = tx_sout;
                    srdy_d   = tx_count < TX_LASTHI;
                end
            end
            ST_DRAIN: ;
            default: ;
        endcase
    end

    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            loc_address   <= '0;
            loc_writedata <= '0;
            loc_write     <= 1'b0;
            loc_read      <= 1'b0;
            sdo           <= 1'b0;
            srdy          <= 1'b0;
            frame_err     <= 1'b0;
            stall_cnt     <= '0;
        end else begin
            loc_address   <= loc_address_d;
            loc_writedata <= loc_writedata_d;
            loc_write     <= loc_write_d;
            loc_read      <= loc_read_d;
            sdo           <= sdo_d;
            srdy          <= srdy_d;
            frame_err     <= frame_err_d;
            stall_cnt     <= stall_cnt_d;
        end
    end

endmodule
